arb_mem_responder: RTL and testbench

Memory-side responder for the 4-master round-robin arbiter. It accepts the single granted request stream from the arbiter output, buffers it in a small in-order queue, and services each request against an internal word-addressed memory after a fixed programmable latency. It returns `rdata` with a one-cycle `rdata_ack` pulse, and echoes the master ID so the interconnect can route the response back to the originating master.

---
 rtl/arb_mem_responder.sv | 148 ++++++++++++++
 tb/tb_arb_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mem_responder.sv
// Memory-side responder: queues granted arbiter requests in order and services each
// against an internal word memory after a fixed latency, echoing the master id.
module arb_mem_responder #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LATENCY    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_id,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_ack,
    output logic [1:0]        rsp_id,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

    typedef struct packed {
        logic              write;
        logic [1:0]        id;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    req_t              fifo_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] mem      [MEM_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_nxt;
    logic [CNT_W-1:0] cnt;
    state_t           state;

    req_t             head;
    logic             push;
    logic             pop;
    logic             access;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    // Ready is held low during reset so nothing is accepted before release.
    assign req_ready = reset && (count < FULL_CNT);
    assign push      = req_valid && req_ready;
    assign pop       = (state == S_RESP);
    assign count_nxt = count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

    assign head     = fifo_mem[rd_ptr];
    assign access   = (state == S_WAIT) && (cnt == '0);
    assign idx      = head.addr[IDX_W-1:0];
    assign in_range = ((head.addr >> IDX_W) == '0);

    // Queue storage carries no reset; only the pointers/count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_t'{write: req_write, id: req_id, addr: req_addr, wdata: req_wdata};
        end
    end

    // Memory keeps its contents across reset; writes land on the access edge.
    always_ff @(posedge clk) begin
        if (access && head.write && in_range) begin
            mem[idx] <= head.wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rdata_ack <= 1'b0;
            rdata     <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rdata_ack <= 1'b0;
            count     <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state <= S_WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state     <= S_RESP;
                        rdata_ack <= 1'b1;
                        rsp_id    <= head.id;
                        rsp_err   <= !in_range;
                        if (!in_range) begin
                            rdata <= ERR_DATA;
                        end else if (head.write) begin
                            rdata <= '0;
                        end else begin
                            rdata <= mem[idx];
                        end
                    end
                end
                S_RESP: begin
                    // A request pushed on the pop edge still counts toward staying busy.
                    if (count_nxt != '0) begin
                        state <= S_WAIT;
                        cnt   <= CNT_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_mem_responder.sv
// Bench for arb_mem_responder: two lanes (LATENCY=2 and LATENCY=1) checked every cycle
// against a queue-based timing/data model built from the acceptance times.
module tb_arb_mem_responder;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MEM_DEPTH = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [1:0]       req_valid_v;
    logic [1:0]       req_write_v;
    logic [1:0]       req_ready_v;
    logic [1:0]       rdata_ack_v;
    logic [1:0]       rsp_err_v;
    logic [1:0][1:0]  req_id_v;
    logic [1:0][1:0]  rsp_id_v;
    logic [1:0][31:0] req_addr_v;
    logic [1:0][31:0] req_wdata_v;
    logic [1:0][31:0] rdata_v;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int outstanding [2];

    typedef struct {
        int          ack_edge;
        logic        write;
        logic [1:0]  id;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int unsigned LAT = (g == 0) ? 2 : 1;

        arb_mem_responder #(
            .DATA_W    (32),
            .ADDR_W    (32),
            .MEM_DEPTH (MEM_DEPTH),
            .FIFO_DEPTH(DEPTH),
            .LATENCY   (LAT)
        ) dut (
            .clk      (clk),
            .reset    (reset),
            .req_valid(req_valid_v[g]),
            .req_ready(req_ready_v[g]),
            .req_write(req_write_v[g]),
            .req_id   (req_id_v[g]),
            .req_addr (req_addr_v[g]),
            .req_wdata(req_wdata_v[g]),
            .rdata    (rdata_v[g]),
            .rdata_ack(rdata_ack_v[g]),
            .rsp_id   (rsp_id_v[g]),
            .rsp_err  (rsp_err_v[g])
        );

        exp_t        q [$];
        exp_t        e;
        logic [31:0] mm [int];
        logic [31:0] last_data = '0;
        logic [31:0] exp_data;
        logic        last_known = 1'b1;
        logic        data_known;
        logic        exp_err;
        logic [1:0]  last_id = '0;
        logic        last_err = 1'b0;
        int          prev_ack = -10;
        int          acc_edge;
        int          wait_edge;

        // Response k is due LAT edges after its wait starts; the wait starts right after
        // the previous response's pop edge, or one edge after acceptance if the server idled.
        always @(negedge clk) begin
            if (!reset) begin
                q.delete();
                prev_ack   = -10;
                last_data  = '0;
                last_known = 1'b1;
                last_id    = '0;
                last_err   = 1'b0;
                check_eq($sformatf("rst_ready%0d", g), 32'(req_ready_v[g]), 32'd0);
                check_eq($sformatf("rst_ack%0d", g), 32'(rdata_ack_v[g]), 32'd0);
            end else begin
                check_eq($sformatf("ready%0d", g), 32'(req_ready_v[g]), 32'(q.size() < DEPTH));
                if (q.size() > 0 && q[0].ack_edge == cyc) begin
                    e = q.pop_front();
                    data_known = 1'b1;
                    exp_err    = 1'b0;
                    if (e.addr >= MEM_DEPTH) begin
                        exp_data = 32'hDEAD_BEEF;
                        exp_err  = 1'b1;
                    end else if (e.write) begin
                        mm[int'(e.addr)] = e.wdata;
                        exp_data = '0;
                    end else if (mm.exists(int'(e.addr))) begin
                        exp_data = mm[int'(e.addr)];
                    end else begin
                        exp_data   = '0;
                        data_known = 1'b0;
                    end
                    check_eq($sformatf("ack_pulse%0d", g), 32'(rdata_ack_v[g]), 32'd1);
                    check_eq($sformatf("ack_id%0d", g), 32'(rsp_id_v[g]), 32'(e.id));
                    check_eq($sformatf("ack_err%0d", g), 32'(rsp_err_v[g]), 32'(exp_err));
                    if (data_known) begin
                        check_eq($sformatf("ack_data%0d", g), rdata_v[g], exp_data);
                    end
                    last_data  = exp_data;
                    last_known = data_known;
                    last_id    = e.id;
                    last_err   = exp_err;
                end else begin
                    check_eq($sformatf("ack_idle%0d", g), 32'(rdata_ack_v[g]), 32'd0);
                    check_eq($sformatf("hold_id%0d", g), 32'(rsp_id_v[g]), 32'(last_id));
                    check_eq($sformatf("hold_err%0d", g), 32'(rsp_err_v[g]), 32'(last_err));
                    if (last_known) begin
                        check_eq($sformatf("hold_data%0d", g), rdata_v[g], last_data);
                    end
                end
                if (req_valid_v[g] && req_ready_v[g]) begin
                    acc_edge   = cyc + 1;
                    wait_edge  = (acc_edge <= prev_ack + 1) ? prev_ack + 1 : acc_edge + 1;
                    e.ack_edge = wait_edge + int'(LAT);
                    e.write    = req_write_v[g];
                    e.id       = req_id_v[g];
                    e.addr     = req_addr_v[g];
                    e.wdata    = req_wdata_v[g];
                    prev_ack   = e.ack_edge;
                    q.push_back(e);
                end
            end
            outstanding[g] = q.size();
        end
    end

    // Presents one request, holds it until accepted, then returns at posedge+1.
    task automatic send(input int g, input logic wr, input logic [1:0] id,
                        input logic [31:0] addr, input logic [31:0] wd);
        bit ok;
        ok = 1'b0;
        req_write_v[g] = wr;
        req_id_v[g]    = id;
        req_addr_v[g]  = addr;
        req_wdata_v[g] = wd;
        req_valid_v[g] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready_v[g]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check_eq("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid_v[g] = 1'b0;
    endtask

    task automatic drain(input int g);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (outstanding[g] == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("drain_timeout", 32'd0, 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic random_traffic(input int g, input int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] addr;
            int          gap;
            addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(256, 400))
                                               : 32'($urandom_range(0, 15));
            send(g, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), addr, $urandom);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        req_valid_v = '0;
        req_write_v = '0;
        req_id_v    = '0;
        req_addr_v  = '0;
        req_wdata_v = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check_eq("post_rst_ready", 32'(req_ready_v[g]), 32'd1);
            check_eq("post_rst_rdata", rdata_v[g], 32'd0);
            check_eq("post_rst_id", 32'(rsp_id_v[g]), 32'd0);
            check_eq("post_rst_err", 32'(rsp_err_v[g]), 32'd0);
        end
        @(posedge clk);
        #1;

        // Single write then read.
        send(0, 1'b1, 2'd1, 32'h10, 32'hA5A5_0001);
        drain(0);
        send(0, 1'b0, 2'd1, 32'h10, 32'h0);
        drain(0);

        // Back-pressure: four fill the queue, the rest wait for a pop.
        send(0, 1'b0, 2'd0, 32'h10, 32'h0);
        send(0, 1'b0, 2'd1, 32'h10, 32'h0);
        send(0, 1'b0, 2'd2, 32'h10, 32'h0);
        send(0, 1'b0, 2'd3, 32'h10, 32'h0);
        @(negedge clk);
        check_eq("bp_ready_low", 32'(req_ready_v[0]), 32'd0);
        @(posedge clk);
        #1;
        send(0, 1'b0, 2'd0, 32'h10, 32'h0);
        send(0, 1'b0, 2'd1, 32'h10, 32'h0);
        drain(0);

        // Read-after-write with no gap.
        send(0, 1'b1, 2'd2, 32'd5, 32'h1234);
        send(0, 1'b0, 2'd3, 32'd5, 32'h0);
        drain(0);

        // Out of range and aliasing.
        send(0, 1'b0, 2'd0, 32'd256, 32'h0);
        send(0, 1'b1, 2'd1, 32'd44, 32'h0000_0044);
        send(0, 1'b1, 2'd2, 32'd300, 32'h0BAD_0BAD);
        send(0, 1'b0, 2'd3, 32'd44, 32'h0);
        drain(0);

        // Reset during the first request's wait discards the whole queue.
        send(0, 1'b1, 2'd0, 32'd7, 32'h0000_0077);
        drain(0);
        send(0, 1'b1, 2'd1, 32'd7, 32'h0000_0099);
        send(0, 1'b0, 2'd2, 32'd7, 32'h0);
        send(0, 1'b0, 2'd3, 32'd7, 32'h0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_eq("mid_rst_no_ack", 32'(rdata_ack_v[0]), 32'd0);
        end
        check_eq("mid_rst_ready", 32'(req_ready_v[0]), 32'd1);
        @(posedge clk);
        #1;
        send(0, 1'b0, 2'd1, 32'd7, 32'h0);
        drain(0);

        random_traffic(0, 40);
        drain(0);

        // LATENCY=1 lane: single access then a continuous stream.
        send(1, 1'b1, 2'd2, 32'd3, 32'hC0DE_0003);
        drain(1);
        for (int k = 0; k < 6; k++) begin
            send(1, 1'b0, 2'(k), 32'd3, 32'h0);
        end
        drain(1);
        random_traffic(1, 30);
        drain(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
